// File: rtl/non_max_sup_if.sv
// Read/write/control bundle between the NMS core and its source/destination buffers.
interface non_max_sup_if #(
    parameter int unsigned COORD_BITS = 3,
    parameter int unsigned PXL_BITS   = 12
);
    logic                       run;
    logic                       done;
    logic                       rd_en;
    logic [COORD_BITS-1:0]      rd_x;
    logic [COORD_BITS-1:0]      rd_y;
    logic [9*PXL_BITS-1:0]      rd_data_flat;
    logic [1:0]                 rd_dir;
    logic                       wr_en;
    logic [COORD_BITS-1:0]      wr_x;
    logic [COORD_BITS-1:0]      wr_y;
    logic signed [PXL_BITS-1:0] wr_data_pxl;

    modport master (
        input  run, rd_data_flat, rd_dir,
        output done, rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data_pxl
    );

    modport slave (
        output run, rd_data_flat, rd_dir,
        input  done, rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data_pxl
    );
endinterface

// File: rtl/non_max_sup.sv
// Raster-scan non-maximum suppression: keeps a gradient pixel only if its magnitude
// is at least that of both neighbours along its quantised gradient direction.
module non_max_sup #(
    parameter int unsigned IMG_WD     = 8,
    parameter int unsigned IMG_HT     = 8,
    parameter int unsigned COORD_BITS = 3,
    parameter int unsigned PXL_BITS   = 12
) (
    input  logic             clk,
    input  logic             rst,
    non_max_sup_if.master    bus
);
    localparam int unsigned MAG_W = PXL_BITS + 1;
    localparam logic [COORD_BITS-1:0] X_MAX = COORD_BITS'(IMG_WD - 1);
    localparam logic [COORD_BITS-1:0] Y_MAX = COORD_BITS'(IMG_HT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [COORD_BITS-1:0]  x_cnt;
    logic [COORD_BITS-1:0]  y_cnt;
    logic                   s1_valid;
    logic [COORD_BITS-1:0]  s1_x;
    logic [COORD_BITS-1:0]  s1_y;

    logic signed [PXL_BITS-1:0] win [9];
    logic signed [PXL_BITS-1:0] nb_a;
    logic signed [PXL_BITS-1:0] nb_b;
    logic                       is_border;
    logic signed [PXL_BITS-1:0] nms_c;

    // One extra bit so the most negative value has a representable magnitude
    function automatic logic [MAG_W-1:0] mag(input logic signed [PXL_BITS-1:0] v);
        logic signed [MAG_W-1:0] e;
        e = MAG_W'(v);
        return e[MAG_W-1] ? MAG_W'(-e) : MAG_W'(e);
    endfunction

    // Suppression decision on the window returned for the stage-1 pixel
    always_comb begin
        nms_c = '0;
        nb_a  = '0;
        nb_b  = '0;
        for (int i = 0; i < 9; i++) begin
            win[i] = bus.rd_data_flat[i*PXL_BITS +: PXL_BITS];
        end
        case (bus.rd_dir)
            2'd0:    begin nb_a = win[3]; nb_b = win[5]; end
            2'd1:    begin nb_a = win[2]; nb_b = win[6]; end
            2'd2:    begin nb_a = win[1]; nb_b = win[7]; end
            default: begin nb_a = win[0]; nb_b = win[8]; end
        endcase
        is_border = (s1_x == '0) || (s1_x == X_MAX) || (s1_y == '0) || (s1_y == Y_MAX);
        if (!is_border && (mag(win[4]) >= mag(nb_a)) && (mag(win[4]) >= mag(nb_b))) begin
            nms_c = win[4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            x_cnt           <= '0;
            y_cnt           <= '0;
            s1_valid        <= 1'b0;
            s1_x            <= '0;
            s1_y            <= '0;
            bus.done        <= 1'b0;
            bus.rd_en       <= 1'b0;
            bus.rd_x        <= '0;
            bus.rd_y        <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_x        <= '0;
            bus.wr_y        <= '0;
            bus.wr_data_pxl <= '0;
        end else begin
            // Pipeline advances independently of run so in-flight pixels always complete
            s1_valid        <= bus.rd_en;
            s1_x            <= bus.rd_x;
            s1_y            <= bus.rd_y;
            bus.wr_en       <= s1_valid;
            bus.wr_x        <= s1_x;
            bus.wr_y        <= s1_y;
            bus.wr_data_pxl <= s1_valid ? nms_c : '0;
            bus.rd_en       <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.run) state <= SCAN;
                end
                SCAN: begin
                    if (bus.run) begin
                        bus.rd_en <= 1'b1;
                        bus.rd_x  <= x_cnt;
                        bus.rd_y  <= y_cnt;
                        if (x_cnt == X_MAX) begin
                            x_cnt <= '0;
                            if (y_cnt == Y_MAX) begin
                                state <= DRAIN;
                            end else begin
                                y_cnt <= y_cnt + 1'b1;
                            end
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.wr_en && (bus.wr_x == X_MAX) && (bus.wr_y == Y_MAX)) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.run) begin
                        state    <= IDLE;
                        bus.done <= 1'b0;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        bus.rd_x <= '0;
                        bus.rd_y <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_non_max_sup.sv
// Bench for non_max_sup on a 4x4 frame: timing, suppression cases, pause and mid-scan reset.
module tb_non_max_sup;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned CB = 3;
    localparam int unsigned P  = 12;

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    non_max_sup_if #(.COORD_BITS(CB), .PXL_BITS(P)) bus ();

    non_max_sup #(.IMG_WD(W), .IMG_HT(H), .COORD_BITS(CB), .PXL_BITS(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [9*P-1:0] win_mem [W*H];
    logic [1:0]     dir_mem [W*H];
    wr_t            sb [$];
    int             total = 0;
    int             bad   = 0;

    // Source buffer: window and direction returned one cycle after a read request
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_flat <= win_mem[int'(bus.rd_y) * W + int'(bus.rd_x)];
            bus.rd_dir       <= dir_mem[int'(bus.rd_y) * W + int'(bus.rd_x)];
        end
    end

    function automatic int exp_pix(int x, int y);
        int v [9];
        int a, b, c;
        logic [9*P-1:0] w;
        w = win_mem[y*W + x];
        for (int i = 0; i < 9; i++) v[i] = int'($signed(w[i*P +: P]));
        case (dir_mem[y*W + x])
            2'd0:    begin a = v[3]; b = v[5]; end
            2'd1:    begin a = v[2]; b = v[6]; end
            2'd2:    begin a = v[1]; b = v[7]; end
            default: begin a = v[0]; b = v[8]; end
        endcase
        c = v[4];
        if (x == 0 || x == W-1 || y == 0 || y == H-1) return 0;
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        if (((c < 0) ? -c : c) >= a && ((c < 0) ? -c : c) >= b) return c;
        return 0;
    endfunction

    task automatic load_random();
        for (int i = 0; i < W*H; i++) begin
            for (int k = 0; k < 9; k++) win_mem[i][k*P +: P] = P'($urandom);
            dir_mem[i] = 2'($urandom);
        end
    endtask

    task automatic push_model();
        wr_t e;
        sb.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.x = x; e.y = y; e.d = exp_pix(x, y);
                sb.push_back(e);
            end
        end
    endtask

    task automatic set_el(int x, int y, int r, int c, int val);
        win_mem[y*W + x][(r*3 + c)*P +: P] = P'(val);
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", bus.rd_en); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); end
        total++;
        if ({bus.rd_x, bus.rd_y, bus.wr_x, bus.wr_y} !== '0) begin
            bad++; $display("FAIL reset_coords got rd=(%0d,%0d) wr=(%0d,%0d) want all 0",
                            bus.rd_x, bus.rd_y, bus.wr_x, bus.wr_y);
        end
        total++; if (bus.wr_data_pxl !== '0) begin bad++; $display("FAIL reset_wr_data got=%0d want=0", bus.wr_data_pxl); end
        rst = 1'b0;
    endtask

    task automatic test_frame_timing();
        wr_t e;
        int  t;
        load_random();
        push_model();
        @(negedge clk);
        bus.run = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.rd_en && t < 10);
        if (!bus.rd_en) begin
            total++; bad++; $display("FAIL timing_start rd_en got=0 want=1 within 10 cycles");
        end else begin
            for (int cyc = 0; cyc < 22; cyc++) begin
                total++;
                if (bus.rd_en !== (cyc < 16)) begin
                    bad++; $display("FAIL timing_rd_en cyc=%0d got=%b want=%b", cyc, bus.rd_en, cyc < 16);
                end
                if (cyc < 16) begin
                    total++;
                    if (int'(bus.rd_x) != cyc % W || int'(bus.rd_y) != cyc / W) begin
                        bad++; $display("FAIL timing_rd_xy cyc=%0d got=(%0d,%0d) want=(%0d,%0d)",
                                        cyc, bus.rd_x, bus.rd_y, cyc % W, cyc / W);
                    end
                end
                total++;
                if (bus.wr_en !== (cyc >= 2 && cyc < 18)) begin
                    bad++; $display("FAIL timing_wr_en cyc=%0d got=%b want=%b", cyc, bus.wr_en, cyc >= 2 && cyc < 18);
                end
                if (bus.wr_en) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++; $display("FAIL timing_wr_extra got write (%0d,%0d) want none", bus.wr_x, bus.wr_y);
                    end else begin
                        e = sb.pop_front();
                        if (int'(bus.wr_x) != e.x || int'(bus.wr_y) != e.y || int'($signed(bus.wr_data_pxl)) != e.d) begin
                            bad++; $display("FAIL timing_wr got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                                            bus.wr_x, bus.wr_y, $signed(bus.wr_data_pxl), e.x, e.y, e.d);
                        end
                    end
                end
                total++;
                if (bus.done !== (cyc >= 18)) begin
                    bad++; $display("FAIL timing_done cyc=%0d got=%b want=%b", cyc, bus.done, cyc >= 18);
                end
                @(negedge clk);
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL timing_missing got %0d unwritten want 0", sb.size()); end
        go_idle();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL idle_done got=%b want=0", bus.done); end
    endtask

    task automatic test_nms_cases();
        wr_t e;
        int  wrs;
        for (int i = 0; i < W*H; i++) begin
            win_mem[i] = '0;
            dir_mem[i] = 2'd0;
        end
        // Border windows that would survive if borders were not forced to zero
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (x == 0 || x == W-1 || y == 0 || y == H-1) set_el(x, y, 1, 1, 1000);
        dir_mem[1*W+1] = 2'd0; set_el(1, 1, 1, 1, -100); set_el(1, 1, 1, 0, 90);  set_el(1, 1, 1, 2, -99);
        dir_mem[1*W+2] = 2'd0; set_el(2, 1, 1, 1, -100); set_el(2, 1, 1, 0, 90);  set_el(2, 1, 1, 2, 101);
        dir_mem[2*W+1] = 2'd2; set_el(1, 2, 1, 1, 50);   set_el(1, 2, 0, 1, 50);  set_el(1, 2, 2, 1, -50);
        dir_mem[2*W+2] = 2'd3; set_el(2, 2, 1, 1, -2048); set_el(2, 2, 0, 0, 2047); set_el(2, 2, 2, 2, 0);
        sb.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.x = x; e.y = y; e.d = 0;
                if (x == 1 && y == 1) e.d = -100;
                if (x == 1 && y == 2) e.d = 50;
                if (x == 2 && y == 2) e.d = -2048;
                sb.push_back(e);
            end
        end
        wrs = 0;
        @(negedge clk);
        bus.run = 1'b1;
        for (int c = 0; c < 60 && !bus.done; c++) begin
            @(negedge clk);
            if (bus.wr_en) begin
                wrs++;
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL nms_wr_extra got write (%0d,%0d) want none", bus.wr_x, bus.wr_y);
                end else begin
                    e = sb.pop_front();
                    if (int'(bus.wr_x) != e.x || int'(bus.wr_y) != e.y || int'($signed(bus.wr_data_pxl)) != e.d) begin
                        bad++; $display("FAIL nms_wr got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                                        bus.wr_x, bus.wr_y, $signed(bus.wr_data_pxl), e.x, e.y, e.d);
                    end
                end
            end
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL nms_done got=%b want=1", bus.done); end
        total++; if (wrs != W*H) begin bad++; $display("FAIL nms_count got=%0d want=%0d", wrs, W*H); end
        go_idle();
    endtask

    task automatic test_pause();
        wr_t e;
        int  rds, wrs, pause;
        logic [CB-1:0] hx, hy;
        load_random();
        push_model();
        rds = 0; wrs = 0; pause = 0; hx = '0; hy = '0;
        @(negedge clk);
        bus.run = 1'b1;
        for (int c = 0; c < 80 && !bus.done; c++) begin
            @(negedge clk);
            if (pause > 0) begin
                total++;
                if (bus.rd_en !== 1'b0 || bus.rd_x !== hx || bus.rd_y !== hy) begin
                    bad++; $display("FAIL pause_hold got rd_en=%b (%0d,%0d) want 0 (%0d,%0d)",
                                    bus.rd_en, bus.rd_x, bus.rd_y, hx, hy);
                end
                pause--;
                if (pause == 0) bus.run = 1'b1;
            end
            if (bus.rd_en) begin
                total++;
                if (int'(bus.rd_x) != rds % W || int'(bus.rd_y) != rds / W) begin
                    bad++; $display("FAIL pause_rd_xy got=(%0d,%0d) want=(%0d,%0d)", bus.rd_x, bus.rd_y, rds % W, rds / W);
                end
                rds++;
                if (rds == 6) begin
                    bus.run = 1'b0; pause = 3; hx = bus.rd_x; hy = bus.rd_y;
                end
            end
            if (bus.wr_en) begin
                wrs++;
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL pause_wr_extra got write (%0d,%0d) want none", bus.wr_x, bus.wr_y);
                end else begin
                    e = sb.pop_front();
                    if (int'(bus.wr_x) != e.x || int'(bus.wr_y) != e.y || int'($signed(bus.wr_data_pxl)) != e.d) begin
                        bad++; $display("FAIL pause_wr got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                                        bus.wr_x, bus.wr_y, $signed(bus.wr_data_pxl), e.x, e.y, e.d);
                    end
                end
            end
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL pause_done got=%b want=1", bus.done); end
        total++; if (rds != W*H) begin bad++; $display("FAIL pause_reads got=%0d want=%0d", rds, W*H); end
        total++; if (wrs != W*H) begin bad++; $display("FAIL pause_writes got=%0d want=%0d", wrs, W*H); end
        go_idle();
    endtask

    task automatic test_reset_midscan();
        wr_t e;
        int  rds, wrs;
        bit  first;
        load_random();
        rds = 0;
        @(negedge clk);
        bus.run = 1'b1;
        for (int c = 0; c < 20 && rds < 5; c++) begin
            @(negedge clk);
            if (bus.rd_en) rds++;
        end
        total++; if (rds != 5) begin bad++; $display("FAIL rst_mid_reads got=%0d want=5", rds); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid_wr_en got=%b want=0", bus.wr_en); end
        total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL rst_mid_rd_en got=%b want=0", bus.rd_en); end
        push_model();
        rds = 0; wrs = 0; first = 1'b1;
        for (int c = 0; c < 60 && !bus.done; c++) begin
            @(negedge clk);
            if (bus.rd_en) begin
                if (first) begin
                    total++;
                    if (bus.rd_x !== '0 || bus.rd_y !== '0) begin
                        bad++; $display("FAIL rst_restart_xy got=(%0d,%0d) want=(0,0)", bus.rd_x, bus.rd_y);
                    end
                    first = 1'b0;
                end
                rds++;
            end
            if (bus.wr_en) begin
                wrs++;
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rst_wr_extra got write (%0d,%0d) want none", bus.wr_x, bus.wr_y);
                end else begin
                    e = sb.pop_front();
                    if (int'(bus.wr_x) != e.x || int'(bus.wr_y) != e.y || int'($signed(bus.wr_data_pxl)) != e.d) begin
                        bad++; $display("FAIL rst_wr got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                                        bus.wr_x, bus.wr_y, $signed(bus.wr_data_pxl), e.x, e.y, e.d);
                    end
                end
            end
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rst_done got=%b want=1", bus.done); end
        total++; if (wrs != W*H) begin bad++; $display("FAIL rst_writes got=%0d want=%0d", wrs, W*H); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_nms_cases();
        test_pause();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/non_max_sup.md
NON_MAX_SUP -- requirements
Module: non_max_sup

Interface
REQ-001 SHALL have parameter IMG_WD, default 8, image width in pixels.
REQ-002 SHALL have parameter IMG_HT, default 8, image height in pixels.
REQ-003 SHALL have parameter COORD_BITS, default 3, bits per X/Y coordinate.
REQ-004 SHALL have parameter PXL_BITS, default 12, signed gradient pixel width.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port run  in  1  scan enable; low pauses read issue.
REQ-008 SHALL have port done  out  1  high when every pixel has been written.
REQ-009 SHALL have port rd_en  out  1  source read request.
REQ-010 SHALL have ports rd_x, rd_y  out  COORD_BITS  centre coordinate of the requested window.
REQ-011 SHALL have port rd_data_flat  in  9*PXL_BITS  3x3 signed gradient window, row-major, element [y][x] at bit (y*3+x)*PXL_BITS; valid one cycle after rd_en.
REQ-012 SHALL have port rd_dir  in  2  quantised gradient direction of the centre pixel; timing as rd_data_flat.
REQ-013 SHALL have port wr_en  out  1  destination write strobe.
REQ-014 SHALL have ports wr_x, wr_y  out  COORD_BITS  write coordinate.
REQ-015 SHALL have port wr_data_pxl  out  PXL_BITS  signed thinned gradient.

Function
REQ-016 SHALL implement FSM IDLE -> SCAN (run=1) -> DRAIN (last read issued) -> DONE (pipeline empty) -> IDLE (run=0).
REQ-017 SHALL, in SCAN, with run=1, issue rd_en=1 for the current (x,y) each cycle, raster order, x wrapping IMG_WD-1 -> 0 with y+1.
REQ-018 SHALL, in SCAN, with run=0, hold rd_en=0 and the coordinates; in-flight pipeline stages continue to complete.
REQ-019 SHALL use a 2-cycle pipeline: read at cycle N, data captured at N+1, wr_en/wr_x/wr_y/wr_data_pxl registered and valid at N+2.
REQ-020 SHALL carry a valid bit and coordinates through each stage; wr_en = valid of the final stage only.
REQ-021 SHALL select neighbours by rd_dir: 0 -> [1][0],[1][2]; 1 -> [0][2],[2][0]; 2 -> [0][1],[2][1]; 3 -> [0][0],[2][2].
REQ-022 SHALL compute magnitudes as absolute values at PXL_BITS+1 bits, so the most negative input does not overflow.
REQ-023 SHALL output the centre value unchanged, sign preserved, when |centre| >= both neighbour magnitudes; ties are kept; otherwise output 0.
REQ-024 SHALL output 0 for border pixels (x=0, x=IMG_WD-1, y=0, y=IMG_HT-1), ignoring window content.
REQ-025 SHALL enter DRAIN after the read of (IMG_WD-1, IMG_HT-1) and DONE on the cycle after its write.
REQ-026 SHALL hold done=1 only in DONE; run=1 in DONE issues no further reads or writes.
REQ-027 SHALL, on leaving DONE for IDLE, zero the coordinates so a later run=1 rescans the whole frame.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE; zero the coordinates; clear all valid bits; drive done=0, rd_en=0, wr_en=0, rd_x=rd_y=wr_x=wr_y=0, wr_data_pxl=0.
REQ-029 SHALL, on rst mid-scan, discard in-flight pixels with no write on the following cycle; rst takes priority over run.

Verification
REQ-030 SHALL cover a 4x4 image with run held high: rd_en on cycles 0-15; wr_en on cycles 2-17 in raster order; done=1 from cycle 18.
REQ-031 SHALL cover interior pixel rd_dir=0, centre=-100, [1][0]=90, [1][2]=-99 -> wr_data_pxl=-100; with [1][2]=101 instead -> 0.
REQ-032 SHALL cover a tie: rd_dir=2, centre=50, [0][1]=50, [2][1]=-50 -> wr_data_pxl=50.
REQ-033 SHALL cover a most-negative centre value -2048 against neighbours 2047 and 0 (PXL_BITS=12) -> -2048 kept.
REQ-034 SHALL cover a run=0 pulse of 3 cycles mid-row: coordinates frozen, no skipped or duplicated writes, total writes = IMG_WD*IMG_HT.
REQ-035 SHALL cover rst=1 for 1 cycle after 5 reads: wr_en=0 next cycle, then run=1 restarts at (0,0).
